// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: one requester port of the data memory arbiter.
// Ports: Req/Wr/Addr/WData in; Gnt/Err/RData/RValid back to requester.
interface data_mem_arbiter_if;
    logic        Req;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic        Gnt;
    logic        Err;
    logic [15:0] RData;
    logic        RValid;

    modport master (
        output Req, Wr, Addr, WData,
        input  Gnt, Err, RData, RValid
    );

    modport slave (
        input  Req, Wr, Addr, WData,
        output Gnt, Err, RData, RValid
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one big-endian 16-bit data memory between
// port C (CPU) and port D (DMA/debug); IDLE -> ACCESS -> RESP per access.
// Ports: Clock, ResetN (async, active low); cPort/dPort requester
// interfaces; MemAddress/MemWriteData/MemWrite/MemRead to memory,
// MemReadData from memory (combinational read).
// Option: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of C-first.
module data_mem_arbiter #(
    parameter int DEPTH = 128
) (
    input  logic                Clock,
    input  logic                ResetN,
    data_mem_arbiter_if.slave   cPort,
    data_mem_arbiter_if.slave   dPort,
    output logic [15:0]         MemAddress,
    output logic [15:0]         MemWriteData,
    output logic                MemWrite,
    output logic                MemRead,
    input  logic [15:0]         MemReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Highest address whose two bytes both fit inside the memory.
    localparam logic [15:0] MAX_ADDR = 16'(DEPTH - 2);

    state_t      state;
    state_t      nextState;
    logic        grab;
    logic        pickD;
    logic        selWr;
    logic [15:0] selAddr;
    logic [15:0] selWData;
    logic        winD;
    logic        latWr;
    logic        latOk;
    logic [15:0] capData;
    logic [15:0] cRData;
    logic [15:0] dRData;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // rrPtr = 1 means D is preferred when both ports request.
    logic rrPtr;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rrPtr <= 1'b0;
        end else if (grab) begin
            rrPtr <= ~pickD;
        end
    end

    always_comb begin
        pickD = dPort.Req & (~cPort.Req | rrPtr);
    end
`else
    always_comb begin
        pickD = dPort.Req & ~cPort.Req;
    end
`endif

    always_comb begin
        selWr    = pickD ? dPort.Wr    : cPort.Wr;
        selAddr  = pickD ? dPort.Addr  : cPort.Addr;
        selWData = pickD ? dPort.WData : cPort.WData;
        capData  = latOk ? MemReadData : 16'h0000;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Strobes, grants and response pulses are decoded from state so an
    // asynchronous reset removes them at once (an in-flight write is
    // dropped before its commit edge).
    always_comb begin
        nextState    = state;
        grab         = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        cPort.Gnt    = 1'b0;
        cPort.Err    = 1'b0;
        cPort.RValid = 1'b0;
        dPort.Gnt    = 1'b0;
        dPort.Err    = 1'b0;
        dPort.RValid = 1'b0;
        unique case (state)
            IDLE: begin
                if (cPort.Req | dPort.Req) begin
                    grab      = 1'b1;
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                MemWrite  = latWr & latOk;
                MemRead   = ~latWr & latOk;
                cPort.Gnt = ~winD;
                dPort.Gnt = winD;
                cPort.Err = ~winD & ~latOk;
                dPort.Err = winD & ~latOk;
                nextState = RESP;
            end
            RESP: begin
                cPort.RValid = ~winD & ~latWr;
                dPort.RValid = winD & ~latWr;
                nextState    = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            winD         <= 1'b0;
            latWr        <= 1'b0;
            latOk        <= 1'b0;
            MemAddress   <= 16'h0000;
            MemWriteData <= 16'h0000;
            cRData       <= 16'h0000;
            dRData       <= 16'h0000;
        end else begin
            if (grab) begin
                winD         <= pickD;
                latWr        <= selWr;
                latOk        <= (selAddr <= MAX_ADDR);
                MemAddress   <= selAddr;
                MemWriteData <= selWData;
            end
            if (state == ACCESS && !latWr) begin
                if (winD) begin
                    dRData <= capData;
                end else begin
                    cRData <= capData;
                end
            end
        end
    end

    assign cPort.RData = cRData;
    assign dPort.RData = dRData;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized + directed bench with per-port
// scoreboards, a byte-array memory and a reference byte image.
module tb_data_mem_arbiter;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic [15:0] MemAddress;
    logic [15:0] MemWriteData;
    logic [15:0] MemReadData;
    logic        MemWrite;
    logic        MemRead;

    data_mem_arbiter_if cIf ();
    data_mem_arbiter_if dIf ();

    data_mem_arbiter #(.DEPTH(128)) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .cPort        (cIf),
        .dPort        (dIf),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          wr;
        bit          err;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
    } exp_t;

    typedef struct {
        bit isD;
        int cyc;
    } gnt_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        cExp[$];
    exp_t        dExp[$];
    gnt_t        gntLog[$];
    logic [7:0]  mem[128];
    logic [7:0]  refMem[128];

    // Memory: combinational read, write on the rising edge.
    // Out-of-range reads return garbage so the DUT must zero them itself.
    assign MemReadData = (MemAddress <= 16'd126)
        ? {mem[MemAddress[6:0]], mem[MemAddress[6:0] + 7'd1]}
        : 16'hDEAD;

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (MemWrite && MemAddress <= 16'd126) begin
            mem[MemAddress[6:0]]        = MemWriteData[15:8];
            mem[MemAddress[6:0] + 7'd1] = MemWriteData[7:0];
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: an access touches bytes a and a+1, both must exist.
    task automatic mkExp(bit wr, logic [15:0] a, logic [15:0] wd,
                         output exp_t e);
        int idx;
        idx     = int'(a);
        e.wr    = wr;
        e.addr  = a;
        e.wd    = wd;
        e.rd    = 16'h0000;
        e.err   = (idx + 1 > 127);
        if (!e.err) begin
            if (wr) begin
                refMem[idx]     = wd[15:8];
                refMem[idx + 1] = wd[7:0];
            end else begin
                e.rd = {refMem[idx], refMem[idx + 1]};
            end
        end
    endtask

    task automatic txn(bit isD, bit wr, logic [15:0] a, logic [15:0] wd,
                       bit keep, output int lat);
        exp_t e;
        bit   g;
        mkExp(wr, a, wd, e);
        if (isD) dExp.push_back(e);
        else     cExp.push_back(e);
        @(negedge Clock);
        if (isD) begin
            dIf.Req = 1'b1; dIf.Wr = wr; dIf.Addr = a; dIf.WData = wd;
        end else begin
            cIf.Req = 1'b1; cIf.Wr = wr; cIf.Addr = a; cIf.WData = wd;
        end
        lat = 0;
        g   = 1'b0;
        while (!g && lat < 400) begin
            @(negedge Clock);
            lat++;
            g = isD ? dIf.Gnt : cIf.Gnt;
        end
        if (!g) begin
            checks++;
            errors++;
            $display("FAIL grant timeout port=%0d: got 0 want 1", isD);
        end
        if (!keep) begin
            if (isD) dIf.Req = 1'b0;
            else     cIf.Req = 1'b0;
        end
    endtask

    function automatic logic [15:0] badAddr();
        case ($urandom_range(0, 3))
            0:       return 16'h007F;
            1:       return 16'hFFFF;
            2:       return 16'h0080;
            default: return 16'($urandom_range(129, 65535));
        endcase
    endfunction

    // Monitor: response timing, loser stability, grant contents.
    bit          cExpRv, dExpRv;
    logic [15:0] cExpRd, dExpRd, cModR, dModR;

    task automatic onGnt(bit isD);
        exp_t e;
        gntLog.push_back('{isD, cyc});
        if ((isD ? dExp.size() : cExp.size()) == 0) begin
            chk(isD ? "D unexpected grant" : "C unexpected grant", 64'd1, 64'd0);
            return;
        end
        e = isD ? dExp.pop_front() : cExp.pop_front();
        chk(isD ? "D grant err/strobes/addr" : "C grant err/strobes/addr",
            64'({isD ? dIf.Err : cIf.Err, MemWrite, MemRead, MemAddress}),
            64'({e.err, e.wr & !e.err, !e.wr & !e.err, e.addr}));
        chk(isD ? "C err while D granted" : "D err while C granted",
            64'(isD ? cIf.Err : dIf.Err), 64'd0);
        if (e.wr) chk("MemWriteData", 64'(MemWriteData), 64'(e.wd));
        if (isD) begin dExpRv = !e.wr; dExpRd = e.rd; end
        else     begin cExpRv = !e.wr; cExpRd = e.rd; end
    endtask

    always @(negedge Clock) begin
        if (!ResetN) begin
            cExpRv = 0; dExpRv = 0; cModR = 0; dModR = 0;
        end else begin
            if (cExpRv) cModR = cExpRd;
            if (dExpRv) dModR = dExpRd;
            chk("C response", 64'({cIf.RValid, cIf.RData}), 64'({cExpRv, cModR}));
            chk("D response", 64'({dIf.RValid, dIf.RData}), 64'({dExpRv, dModR}));
            cExpRv = 0;
            dExpRv = 0;
            if (cIf.Gnt && dIf.Gnt) chk("double grant", 64'd1, 64'd0);
            if (cIf.Gnt)      onGnt(1'b0);
            else if (dIf.Gnt) onGnt(1'b1);
            else chk("strobes outside access", 64'({MemWrite, MemRead}), 64'd0);
        end
    end

    initial begin
        int         lat;
        int         bad;
        exp_t       e;
        logic [3:0] order;
        logic [3:0] want;

        foreach (mem[i]) begin
            mem[i]    = 8'($urandom);
            refMem[i] = mem[i];
        end
        cIf.Req = 0; cIf.Wr = 0; cIf.Addr = 0; cIf.WData = 0;
        dIf.Req = 0; dIf.Wr = 0; dIf.Addr = 0; dIf.WData = 0;

        repeat (2) @(negedge Clock);
        chk("reset pulses", 64'({cIf.Gnt, cIf.Err, cIf.RValid, dIf.Gnt,
            dIf.Err, dIf.RValid, MemWrite, MemRead}), 64'd0);
        chk("reset data", {cIf.RData, dIf.RData, MemAddress, MemWriteData}, 64'd0);
        #1 ResetN = 1'b1;

        // C write then read back at 0x0002.
        txn(0, 1, 16'h0002, 16'h1234, 0, lat);
        chk("C write grant latency", 64'(lat), 64'd1);
        txn(0, 0, 16'h0002, 16'h0000, 0, lat);
        chk("mem[2..3]", 64'({mem[2], mem[3]}), 64'h1234);

        // D out-of-range read, then top valid write.
        txn(1, 0, 16'h007F, 16'h0000, 0, lat);
        txn(1, 1, 16'h007E, 16'hA55A, 0, lat);
        repeat (3) @(negedge Clock);
        chk("mem[126..127]", 64'({mem[126], mem[127]}), 64'hA55A);

        // Reset in the middle of a C write: nothing must commit.
        e = '{wr: 1'b1, err: 1'b0, addr: 16'h0010, wd: 16'hBEEF, rd: 16'h0};
        cExp.push_back(e);
        @(negedge Clock);
        cIf.Req = 1; cIf.Wr = 1; cIf.Addr = 16'h0010; cIf.WData = 16'hBEEF;
        @(negedge Clock);
        chk("reset-test grant", 64'({cIf.Gnt, MemWrite}), 64'h3);
        cIf.Req = 0;
        #2 ResetN = 1'b0;
        #1 chk("MemWrite drop on reset", 64'(MemWrite), 64'd0);
        chk("mid reset pulses", 64'({cIf.Gnt, cIf.Err, cIf.RValid, dIf.Gnt,
            dIf.Err, dIf.RValid, MemWrite, MemRead}), 64'd0);
        chk("mid reset data", {cIf.RData, dIf.RData, MemAddress, MemWriteData}, 64'd0);
        @(negedge Clock);
        #1 ResetN = 1'b1;
        repeat (2) @(negedge Clock);
        chk("mem[0x10..0x11] kept", 64'({mem[16], mem[17]}),
            64'({refMem[16], refMem[17]}));

        // Both ports held: arbitration order of the first four grants.
        gntLog.delete();
        fork
            for (int i = 0; i < 4; i++) begin
                int l;
                txn(0, 0, 16'($urandom_range(0, 62)), 16'h0, i < 3, l);
            end
            for (int i = 0; i < 2; i++) begin
                int l;
                txn(1, 0, 16'($urandom_range(64, 126)), 16'h0, i < 1, l);
            end
        join
        order = 'x;
        for (int k = 0; k < 4; k++)
            if (k < gntLog.size()) order[k] = gntLog[k].isD;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        want = 4'b1010;
`else
        want = 4'b0000;
`endif
        chk("arbitration order", 64'(order), 64'(want));

        // Back-to-back C reads with Req held.
        gntLog.delete();
        txn(0, 0, 16'h0000, 16'h0, 1, lat);
        txn(0, 0, 16'h0004, 16'h0, 0, lat);
        repeat (3) @(negedge Clock);
        if (gntLog.size() >= 2)
            chk("back-to-back spacing", 64'(gntLog[1].cyc - gntLog[0].cyc), 64'd3);
        else
            chk("back-to-back grants", 64'(gntLog.size()), 64'd2);

        // Random traffic from both ports in disjoint address windows.
        fork
            for (int i = 0; i < 60; i++) begin
                int          l;
                logic [15:0] a;
                repeat ($urandom_range(0, 4)) @(negedge Clock);
                a = ($urandom_range(0, 9) == 0) ? badAddr()
                                                : 16'($urandom_range(0, 62));
                txn(0, 1'($urandom), a, 16'($urandom), 0, l);
            end
            for (int i = 0; i < 60; i++) begin
                int          l;
                logic [15:0] a;
                repeat ($urandom_range(0, 4)) @(negedge Clock);
                a = ($urandom_range(0, 9) == 0) ? badAddr()
                                                : 16'($urandom_range(64, 126));
                txn(1, 1'($urandom), a, 16'($urandom), 0, l);
            end
        join

        repeat (5) @(negedge Clock);
        chk("scoreboard drained", 64'(cExp.size() + dExp.size()), 64'd0);
        bad = 0;
        foreach (mem[i]) if (mem[i] !== refMem[i]) bad++;
        chk("memory image mismatching bytes", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
